// File: rtl/fp_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter_if
// Purpose  : Producer, issue, write-port and bypass signals of the FP writeback arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface fp_wb_arbiter_if #(
  parameter int FLEN = 32
);
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [FLEN-1:0] ld_data;
  logic            ld_ready;
  logic            fpu_valid;
  logic [4:0]      fpu_rd;
  logic [FLEN-1:0] fpu_data;
  logic            fpu_ready;
  logic            wr_en;
  logic [4:0]      rd;
  logic [FLEN-1:0] data_o;
  logic [31:0]     busy_o;
  logic [4:0]      byp_rs1;
  logic [4:0]      byp_rs2;
  logic [4:0]      byp_rs3;
  logic [2:0]      byp_hit_o;
  logic [FLEN-1:0] byp_data_o;

  modport master (
    output iss_valid, iss_rd,
    output ld_valid, ld_rd, ld_data, input ld_ready,
    output fpu_valid, fpu_rd, fpu_data, input fpu_ready,
    input  wr_en, rd, data_o, busy_o,
    output byp_rs1, byp_rs2, byp_rs3,
    input  byp_hit_o, byp_data_o
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  ld_valid, ld_rd, ld_data, output ld_ready,
    input  fpu_valid, fpu_rd, fpu_data, output fpu_ready,
    output wr_en, rd, data_o, busy_o,
    input  byp_rs1, byp_rs2, byp_rs3,
    output byp_hit_o, byp_data_o
  );
endinterface
`default_nettype wire

// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter
// Purpose  : FP writeback stage - two buffered producers, round-robin arbitration,
//            registered register-file write port, pending-write scoreboard.
//            Optional bypass outputs enabled by defining FP_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fp_wb_arbiter #(
  parameter int FLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  fp_wb_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    RR_LD  = 1'b0,
    RR_FPU = 1'b1
  } rr_e;

  // Source 0 is the load path, source 1 is the FPU.
  logic [1:0]            src_valid;
  logic [1:0][4:0]       src_rd;
  logic [1:0][FLEN-1:0]  src_data;
  logic [1:0]            src_ready;
  logic [1:0]            src_nonempty;
  logic [1:0]            src_pop;
  logic [1:0][4:0]       head_rd;
  logic [1:0][FLEN-1:0]  head_data;

  rr_e             rr_q;
  rr_e             rr_d;
  logic            grant;
  logic            gsel;
  logic            wr_q;
  logic [4:0]      rd_q;
  logic [FLEN-1:0] data_q;
  logic [31:0]     busy_q;
  logic [31:0]     busy_d;

  assign src_valid = {bus.fpu_valid, bus.ld_valid};
  assign src_rd    = {bus.fpu_rd,    bus.ld_rd};
  assign src_data  = {bus.fpu_data,  bus.ld_data};

  generate
    for (genvar s = 0; s < 2; s++) begin : g_fifo
      logic [4:0]       mem_rd   [DEPTH];
      logic [FLEN-1:0]  mem_data [DEPTH];
      logic [PTR_W-1:0] wptr;
      logic [PTR_W-1:0] rptr;
      logic [CNT_W-1:0] count;
      logic             push;

      assign src_ready[s]    = (count != CNT_W'(DEPTH));
      assign src_nonempty[s] = (count != '0);
      assign push            = src_valid[s] && src_ready[s] && !flush;
      assign head_rd[s]      = mem_rd[rptr];
      assign head_data[s]    = mem_data[rptr];

      always_ff @(posedge clk) begin
        if (push) begin
          mem_rd[wptr]   <= src_rd[s];
          mem_data[wptr] <= src_data[s];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          wptr  <= '0;
          rptr  <= '0;
          count <= '0;
        end else begin
          if (push) wptr <= wptr + PTR_W'(1);
          if (src_pop[s]) rptr <= rptr + PTR_W'(1);
          case ({push, src_pop[s]})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

  // The pointer only moves when both heads compete.
  always_comb begin
    grant = 1'b0;
    gsel  = 1'b0;
    rr_d  = rr_q;
    case (src_nonempty)
      2'b01: grant = 1'b1;
      2'b10: begin
        grant = 1'b1;
        gsel  = 1'b1;
      end
      2'b11: begin
        grant = 1'b1;
        gsel  = (rr_q == RR_FPU);
        rr_d  = (rr_q == RR_LD) ? RR_FPU : RR_LD;
      end
      default: ;
    endcase
  end

  assign src_pop = grant ? (gsel ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst || flush) rr_q <= RR_LD;
    else              rr_q <= rr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (flush) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= grant;
      if (grant) begin
        rd_q   <= head_rd[gsel];
        data_q <= head_data[gsel];
      end
    end
  end

  // Set is applied after clear so a same-index dispatch wins.
  always_comb begin
    busy_d = busy_q;
    if (grant) busy_d[head_rd[gsel]] = 1'b0;
    if (bus.iss_valid) busy_d[bus.iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) busy_q <= '0;
    else              busy_q <= busy_d;
  end

  assign bus.ld_ready  = src_ready[0];
  assign bus.fpu_ready = src_ready[1];
  assign bus.wr_en     = wr_q;
  assign bus.rd        = rd_q;
  assign bus.data_o    = data_q;
  assign bus.busy_o    = busy_q;

`ifdef FP_WB_BYPASS_EN
  assign bus.byp_hit_o  = {wr_q && (rd_q == bus.byp_rs3),
                           wr_q && (rd_q == bus.byp_rs2),
                           wr_q && (rd_q == bus.byp_rs1)};
  assign bus.byp_data_o = data_q;
`else
  logic unused_byp;
  assign unused_byp     = ^{bus.byp_rs1, bus.byp_rs2, bus.byp_rs3};
  assign bus.byp_hit_o  = 3'b000;
  assign bus.byp_data_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
`default_nettype none
// Bench for fp_wb_arbiter: directed scenarios plus random traffic, checked by a
// queue-based reference model and a negedge monitor.
module tb_fp_wb_arbiter;
  localparam int FLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [4:0]      rd;
    logic [FLEN-1:0] data;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  fp_wb_arbiter_if #(.FLEN(FLEN)) bus();

  fp_wb_arbiter #(.FLEN(FLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  // Reference model state
  res_t            mq_ld[$];
  res_t            mq_fpu[$];
  res_t            exp_q[$];
  bit              m_rr_fpu;
  logic [31:0]     m_busy;
  logic [4:0]      m_rd;
  logic [FLEN-1:0] m_data;

  // Producer / issue stimulus state
  bit   ld_pend, fpu_pend;
  res_t ld_item, fpu_item;
  bit   iss_v;
  logic [4:0] iss_r;

  int checks = 0;
  int passed = 0;
  bit mon_en = 0;
  logic [4:0] wr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  task automatic offer_ld(input logic [4:0] r, input logic [FLEN-1:0] d);
    ld_pend = 1; ld_item.rd = r; ld_item.data = d;
  endtask

  task automatic offer_fpu(input logic [4:0] r, input logic [FLEN-1:0] d);
    fpu_pend = 1; fpu_item.rd = r; fpu_item.data = d;
  endtask

  task automatic model_step();
    bit   ld_acc, fpu_acc, g;
    res_t w;
    ld_acc = 0; fpu_acc = 0; g = 0; w = '0;
    if (rst) begin
      mq_ld.delete(); mq_fpu.delete();
      m_rr_fpu = 0; m_busy = '0; m_rd = '0; m_data = '0;
    end else if (flush) begin
      mq_ld.delete(); mq_fpu.delete();
      m_rr_fpu = 0; m_busy = '0;
    end else begin
      ld_acc  = ld_pend  && (mq_ld.size()  < DEPTH);
      fpu_acc = fpu_pend && (mq_fpu.size() < DEPTH);
      if (mq_ld.size() > 0 && mq_fpu.size() > 0) begin
        w = m_rr_fpu ? mq_fpu.pop_front() : mq_ld.pop_front();
        m_rr_fpu = !m_rr_fpu;
        g = 1;
      end else if (mq_ld.size() > 0) begin
        w = mq_ld.pop_front(); g = 1;
      end else if (mq_fpu.size() > 0) begin
        w = mq_fpu.pop_front(); g = 1;
      end
      if (g) begin
        exp_q.push_back(w);
        m_rd = w.rd; m_data = w.data;
        m_busy[w.rd] = 1'b0;
      end
      if (iss_v) m_busy[iss_r] = 1'b1;
      if (ld_acc)  begin mq_ld.push_back(ld_item);   ld_pend  = 0; end
      if (fpu_acc) begin mq_fpu.push_back(fpu_item); fpu_pend = 0; end
    end
  endtask

  task automatic tick();
    bus.ld_valid  = ld_pend;  bus.ld_rd  = ld_item.rd;  bus.ld_data  = ld_item.data;
    bus.fpu_valid = fpu_pend; bus.fpu_rd = fpu_item.rd; bus.fpu_data = fpu_item.data;
    bus.iss_valid = iss_v;    bus.iss_rd = iss_r;
    @(posedge clk);
    model_step();
    mon_en = 1;
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops the expected-write queue whenever the DUT presents a write.
  always @(negedge clk) begin
    if (mon_en) begin
      res_t w;
      bit   ew;
      logic [2:0] eh;
      ew = (exp_q.size() > 0);
      check("wr_en", {63'd0, bus.wr_en}, {63'd0, ew});
      if (bus.wr_en === 1'b1 && ew) begin
        w = exp_q.pop_front();
        check("wr_rd", {59'd0, bus.rd}, {59'd0, w.rd});
        check("wr_data", {32'd0, bus.data_o}, {32'd0, w.data});
        wr_log.push_back(bus.rd);
      end else if (ew) begin
        void'(exp_q.pop_front());
      end
      check("rd_hold", {59'd0, bus.rd}, {59'd0, m_rd});
      check("data_hold", {32'd0, bus.data_o}, {32'd0, m_data});
      check("busy", {32'd0, bus.busy_o}, {32'd0, m_busy});
      check("ld_ready", {63'd0, bus.ld_ready}, {63'd0, (mq_ld.size() < DEPTH)});
      check("fpu_ready", {63'd0, bus.fpu_ready}, {63'd0, (mq_fpu.size() < DEPTH)});
`ifdef FP_WB_BYPASS_EN
      eh = {ew && (m_rd == bus.byp_rs3), ew && (m_rd == bus.byp_rs2), ew && (m_rd == bus.byp_rs1)};
      check("byp_hit", {61'd0, bus.byp_hit_o}, {61'd0, eh});
      check("byp_data", {32'd0, bus.byp_data_o}, {32'd0, m_data});
`else
      eh = 3'b000;
      check("byp_hit", {61'd0, bus.byp_hit_o}, {61'd0, eh});
      check("byp_data", {32'd0, bus.byp_data_o}, 64'd0);
`endif
    end
  end

  initial begin
    int exp_ord[4];
    exp_ord = '{1, 8, 2, 9};
    rst = 1; flush = 0;
    ld_pend = 0; fpu_pend = 0; ld_item = '0; fpu_item = '0;
    iss_v = 0; iss_r = '0;
    bus.byp_rs1 = '0; bus.byp_rs2 = '0; bus.byp_rs3 = '0;
    tick(); tick();
    rst = 0;

    // Single load
    offer_ld(5'd3, 32'h3F80_0000);
    repeat (3) tick();

    // Scoreboard set, clear, and set-wins
    iss_v = 1; iss_r = 5'd5; tick(); iss_v = 0;
    offer_fpu(5'd5, 32'h4000_0000); tick();
    iss_v = 1; iss_r = 5'd5; tick(); iss_v = 0;
    tick();
    offer_fpu(5'd5, 32'h4040_0000);
    repeat (3) tick();

    // Contention: expected write order 1,8,2,9
    wr_log.delete();
    offer_ld(5'd1, 32'h1111_0001); offer_fpu(5'd8, 32'h8888_0008); tick();
    offer_ld(5'd2, 32'h2222_0002); offer_fpu(5'd9, 32'h9999_0009); tick();
    repeat (4) tick();
    for (int i = 0; i < 4; i++)
      check("rr_order", {59'd0, (wr_log.size() > i) ? wr_log[i] : 5'h1f}, 64'(exp_ord[i]));

    // Backpressure with both producers saturating
    for (int i = 0; i < 8; i++) begin
      if (!ld_pend)  offer_ld(5'(10 + i), 32'($urandom));
      if (!fpu_pend) offer_fpu(5'(20 + i), 32'($urandom));
      tick();
    end
    repeat (6) tick();

    // Flush with two entries buffered and busy = 0x106
    iss_v = 1; iss_r = 5'd1; tick();
    iss_r = 5'd2; tick();
    iss_r = 5'd8; tick(); iss_v = 0;
    offer_ld(5'd1, 32'hAAAA_0001); offer_fpu(5'd2, 32'hBBBB_0002); tick();
    check("busy_pre_flush", {32'd0, m_busy}, 64'h106);
    flush = 1; tick(); flush = 0;
    wr_log.delete();
    repeat (4) tick();
    check("post_flush_writes", 64'(wr_log.size()), 64'd0);

    // Bypass match on rs2
    offer_ld(5'd7, 32'h7777_0007); tick();
    bus.byp_rs1 = 5'd0; bus.byp_rs2 = 5'd7; bus.byp_rs3 = 5'd1;
    tick(); tick();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (!ld_pend && $urandom_range(0, 2) != 0)  offer_ld(5'($urandom), 32'($urandom));
      if (!fpu_pend && $urandom_range(0, 2) != 0) offer_fpu(5'($urandom), 32'($urandom));
      iss_v = ($urandom_range(0, 3) == 0);
      iss_r = 5'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      bus.byp_rs1 = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      bus.byp_rs2 = $urandom_range(0, 1) ? m_rd : 5'($urandom);
      bus.byp_rs3 = 5'($urandom);
      tick();
    end
    iss_v = 0; flush = 0; rst = 0;
    repeat (10) tick();
    check("drain", 64'(exp_q.size() + mq_ld.size() + mq_fpu.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Writeback stage directly upstream of the FP register file (f0..f31, FLEN-bit).
- Accepts results from two producers, the FP load path and the multi-cycle FPU, and buffers each in a 2-entry FIFO.
- Arbitrates round-robin and drives a single registered write port (wr_en/rd/data) into the register file.
- Keeps a 32-bit pending-write scoreboard that the issue stage uses for RAW/WAW stalls.

Parameters:
FLEN, 32, data width of FP registers and result buses
DEPTH, 2, entries per source FIFO (power of two, >=2)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered results and clear scoreboard
iss_valid  in  1  issue stage dispatches an FP-writing instruction
iss_rd  in  5  destination of dispatched instruction
ld_valid  in  1  load result valid
ld_rd  in  5  load destination register
ld_data  in  FLEN  load result
ld_ready  out  1  load FIFO not full
fpu_valid  in  1  FPU result valid
fpu_rd  in  5  FPU destination register
fpu_data  in  FLEN  FPU result
fpu_ready  out  1  FPU FIFO not full
wr_en  out  1  register-file write enable (registered)
rd  out  5  register-file write index (registered)
data_o  out  FLEN  register-file write data (registered)
busy_o  out  32  scoreboard, bit i = write to fi pending
byp_rs1, byp_rs2, byp_rs3  in  5 each  read indices for bypass check
byp_hit_o  out  3  bit k = byp_rs(k+1) matches in-flight write
byp_data_o  out  FLEN  data_o, valid when any byp_hit_o bit set

Behaviour:
- Reset (rst=1 at posedge): FIFOs empty, wr_en=0, rd=0, data_o=0, busy_o=0, RR pointer=load. ld_ready and fpu_ready are 1 from the first cycle after reset.
- Handshake: a transfer occurs when valid&&ready at posedge. The producer holds data while valid&&!ready. ready depends only on FIFO occupancy, with no combinational path from valid.
- FIFO: pointer wrap modulo DEPTH plus a full/empty count. Simultaneous push and pop when full is not possible because ready=0. A simultaneous push and pop on a non-full FIFO keeps the count unchanged.
- Arbitration each cycle among non-empty FIFO heads:
  - Only one non-empty: grant it.
  - Both non-empty: grant the source the RR pointer names, then toggle the pointer to the other source.
  - The pointer toggles only on a contested grant.
- Output register: on a grant, wr_en<=1, rd<=head.rd, data_o<=head.data, head popped. With no grant, wr_en<=0 and rd/data_o hold.
- Latency: accepted at posedge N -> earliest wr_en high in cycle N+1, registered at posedge N+1. The register file captures on the following negedge. No stalls from the register file; throughput is 1 write/cycle.
- Scoreboard:
  - iss_valid sets busy[iss_rd].
  - A grant clears busy[head.rd] at the same posedge the output register loads.
  - Same-index set and clear in one cycle: set wins.
  - The issue stage never dispatches to a busy index, so no WAW tracking is done here.
  - Writes to f0 are ordinary; f0 is not hardwired.
- Flush (not in reset): at posedge, both FIFOs are emptied, busy_o=0, wr_en<=0, and RR pointer=load. A grant computed in that cycle is discarded. Same-cycle valid inputs and iss_valid are ignored. rst has priority over flush.
- Reset mid-operation: all in-flight results are lost. The outputs of the next cycle equal the reset values.

Optional Feature:
FP_WB_BYPASS_EN
- Defined:
  - byp_hit_o[k] = wr_en && (rd == byp_rs(k+1)), combinational.
  - byp_data_o = data_o.
  - Lets an issue stage that samples on posedge pick up a value the register file writes only on the next negedge.
- Undefined: byp_hit_o tied 0 and byp_data_o tied 0. Ports remain for interface stability.

Test Plan:
- Reset then single load: ld_valid=1, ld_rd=3, ld_data=0x3F800000 at cycle 0 -> cycle 1 wr_en=1, rd=3, data_o=0x3F800000; cycle 2 wr_en=0.
- Scoreboard: iss_valid rd=5 -> busy_o[5]=1. The FPU result for rd=5 is granted -> busy_o[5]=0 after that posedge. Same-cycle iss_rd=5 with a grant for rd=5 -> busy_o[5] stays 1.
- Contention: both FIFOs hold 2 entries (ld rd=1,2; fpu rd=8,9) -> write order 1,8,2,9 on four consecutive cycles.
- Backpressure: hold fpu_valid with no grants because load wins the RR turn -> fpu_ready=0 after 2 accepted entries. The held third result is written after a pop without loss or duplication.
- Flush: two entries buffered, busy_o=0x0000_0106, flush=1 -> next cycle wr_en=0, busy_o=0, ld_ready=fpu_ready=1, and no later writes appear.
- With FP_WB_BYPASS_EN: wr_en=1, rd=7, byp_rs2=7 -> byp_hit_o=3'b010, byp_data_o=data_o. Without the macro -> byp_hit_o=0.
